load_store_unit: RTL

Memory-stage load/store unit for the RV32IM pipeline. It sits between the EX/MEM pipeline register and the data memory bus, and replaces the direct address/write-data wiring. It runs a request/response handshake, drives byte enables, steers and sign/zero-extends load data for write-back, and stalls the pipeline until the access completes.

---
 rtl/load_store_unit.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-stage load/store unit. Sits between EX/MEM and the data bus: runs a
//   req/gnt + rvalid handshake, builds byte enables and lane-steered write
//   data, extracts and sign/zero-extends load data, and stalls the pipeline
//   until the access finishes.
//
// Ports
//   clk, rst                  clock, async active-high reset
//   load_i, store_i           MEM-stage access kind (held while stall_o)
//   funct3_i, addr_i, wdata_i access size/sign, byte address, store data
//   stall_o                   pipeline freeze
//   rdata_o                   extended load result (valid in DONE, held after)
//   misaligned_o, fault_o     exception flags, DONE cycle only
//   mem_req_o .. mem_wdata_o  bus request side
//   mem_gnt_i .. mem_err_i    bus grant / response side
//
// Parameter WAIT_LIMIT: grant wait bound in cycles (0 = no timeout).
// Build option LSU_MISALIGNED_SPLIT_EN: when defined, misaligned accesses are
//   performed (word-crossing ones as two bus transactions) instead of trapping.
//
// state | meaning
// IDLE  | waiting for a load/store, decodes legality
// REQ   | first (or only) word request held until grant
// RESP  | waiting for first word response
// REQ2  | second word request of a split access
// RESP2 | waiting for second word response
// DONE  | one-cycle result/flag presentation, pipeline released
module load_store_unit #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o,
  output logic        fault_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_RESP  = 3'd2,
`ifdef LSU_MISALIGNED_SPLIT_EN
    S_REQ2  = 3'd3,
    S_RESP2 = 3'd4,
`endif
    S_DONE  = 3'd5
  } state_t;

  localparam int unsigned CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT);
  // Down-counter start value; terminal count 0 marks the last allowed wait cycle.
  localparam logic [CW-1:0] WAIT_INIT = CW'(WAIT_LIMIT - 1);

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [2:0]    funct3_q, funct3_d;
  logic          we_q, we_d, fault_q, fault_d, misal_q, misal_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [1:0]  off;
  logic [3:0]  base_be;
  logic [31:0] wdata_repl, word_addr;
  logic [63:0] resp_merged;
  logic        req_active, busy, illegal_in, timeout;

  function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [1:0] o,
                                              input logic [63:0] merged);
    logic [31:0] w;
    logic [31:0] res;
    w = 32'(merged >> {o, 3'b000});
    case (f3)
      3'b000:  res = {{24{w[7]}}, w[7:0]};
      3'b001:  res = {{16{w[15]}}, w[15:0]};
      3'b100:  res = {24'h0, w[7:0]};
      3'b101:  res = {16'h0, w[15:0]};
      default: res = w;
    endcase
    return res;
  endfunction

  assign off       = addr_q[1:0];
  assign word_addr = {addr_q[31:2], 2'b00};

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   begin base_be = 4'b0001; wdata_repl = {4{wdata_q[7:0]}};  end
      2'b01:   begin base_be = 4'b0011; wdata_repl = {2{wdata_q[15:0]}}; end
      default: begin base_be = 4'b1111; wdata_repl = wdata_q;            end
    endcase
  end

  assign illegal_in = (load_i & store_i)
                    | (load_i & ((funct3_i == 3'b011) | (funct3_i[2:1] == 2'b11)))
                    | (store_i & funct3_i[2]);
  assign timeout = (WAIT_LIMIT != 0) && (cnt_q == '0);

`ifdef LSU_MISALIGNED_SPLIT_EN
  logic [31:0] first_q, first_d;
  logic [7:0]  be_wide;
  logic [63:0] wdata_wide;
  logic        split, nat_aligned, second;

  // Lanes pushed past bit 3 belong to the following word.
  assign be_wide     = {4'b0000, base_be} << off;
  assign wdata_wide  = {32'h0, wdata_q} << {off, 3'b000};
  assign split       = |be_wide[7:4];
  assign nat_aligned = (funct3_q[1:0] == 2'b00) | ((funct3_q[1:0] == 2'b01) & ~off[0]) | (off == 2'b00);
  assign second      = (state_q == S_REQ2);
  assign req_active  = (state_q == S_REQ) | (state_q == S_REQ2);
  assign busy        = req_active | (state_q == S_RESP) | (state_q == S_RESP2);
  assign mem_addr_o  = !req_active ? 32'h0 : (second ? word_addr + 32'd4 : word_addr);
  assign mem_be_o    = !req_active ? 4'h0 : (second ? be_wide[7:4] : be_wide[3:0]);
  // Replication only lines data up with its lanes when naturally aligned.
  assign mem_wdata_o = !req_active ? 32'h0 :
                       second      ? wdata_wide[63:32] :
                       nat_aligned ? wdata_repl : wdata_wide[31:0];
  assign resp_merged = (state_q == S_RESP2) ? {mem_rdata_i, first_q} : {32'h0, mem_rdata_i};
`else
  logic misal_in;

  assign misal_in    = ((funct3_i[1:0] == 2'b01) & addr_i[0])
                     | ((funct3_i[1:0] == 2'b10) & (addr_i[1:0] != 2'b00));
  assign req_active  = (state_q == S_REQ);
  assign busy        = req_active | (state_q == S_RESP);
  assign mem_addr_o  = req_active ? word_addr : 32'h0;
  assign mem_be_o    = req_active ? (base_be << off) : 4'h0;
  assign mem_wdata_o = req_active ? wdata_repl : 32'h0;
  assign resp_merged = {32'h0, mem_rdata_i};
`endif

  assign mem_req_o    = req_active;
  assign mem_we_o     = req_active & we_q;
  assign stall_o      = ((state_q == S_IDLE) & (load_i | store_i)) | busy;
  assign rdata_o      = rdata_q;
  assign fault_o      = fault_q;
  assign misaligned_o = misal_q;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    we_d     = we_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    fault_d  = 1'b0;
    misal_d  = 1'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
    first_d  = first_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (load_i | store_i) begin
          if (illegal_in) begin
            state_d = S_DONE;
            fault_d = 1'b1;
`ifndef LSU_MISALIGNED_SPLIT_EN
          end else if (misal_in) begin
            state_d = S_DONE;
            misal_d = 1'b1;
`endif
          end else begin
            state_d  = S_REQ;
            addr_d   = addr_i;
            wdata_d  = wdata_i;
            funct3_d = funct3_i;
            we_d     = store_i;
            cnt_d    = WAIT_INIT;
          end
        end
      end
      S_REQ: begin
        if (mem_gnt_i) state_d = S_RESP;
        else if (timeout) begin
          state_d = S_DONE;
          fault_d = 1'b1;
        end else cnt_d = cnt_q - CW'(1);
      end
      S_RESP: begin
        if (mem_rvalid_i) begin
          if (mem_err_i) begin
            state_d = S_DONE;
            fault_d = 1'b1;
`ifdef LSU_MISALIGNED_SPLIT_EN
          end else if (split) begin
            state_d = S_REQ2;
            cnt_d   = WAIT_INIT;
            first_d = mem_rdata_i;
`endif
          end else begin
            state_d = S_DONE;
            if (!we_q) rdata_d = extend_load(funct3_q, off, resp_merged);
          end
        end
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      S_REQ2: begin
        if (mem_gnt_i) state_d = S_RESP2;
        else if (timeout) begin
          state_d = S_DONE;
          fault_d = 1'b1;
        end else cnt_d = cnt_q - CW'(1);
      end
      S_RESP2: begin
        if (mem_rvalid_i) begin
          state_d = S_DONE;
          if (mem_err_i) fault_d = 1'b1;
          else if (!we_q) rdata_d = extend_load(funct3_q, off, resp_merged);
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      funct3_q <= 3'h0;
      we_q     <= 1'b0;
      cnt_q    <= '0;
      rdata_q  <= 32'h0;
      fault_q  <= 1'b0;
      misal_q  <= 1'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      first_q  <= 32'h0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      fault_q  <= fault_d;
      misal_q  <= misal_d;
`ifdef LSU_MISALIGNED_SPLIT_EN
      first_q  <= first_d;
`endif
    end
  end

endmodule
